// File: rtl/lss_seq_shifter_if.sv
// rtl/lss_seq_shifter_if.sv - request/result signal bundle for lss_seq_shifter
interface lss_seq_shifter_if #(
   parameter int N  = 8,
   parameter int SW = 3
);
   logic          start;
   logic [2:0]    mode;
   logic [SW-1:0] amt;
   logic [N-1:0]  din;
   logic          sin;
   logic          busy;
   logic          done;
   logic [N-1:0]  dout;
   logic          cout;

   modport master (
      output start, mode, amt, din, sin,
      input  busy, done, dout, cout
   );

   modport slave (
      input  start, mode, amt, din, sin,
      output busy, done, dout, cout
   );
endinterface

// File: rtl/lss_seq_shifter.sv
// rtl/lss_seq_shifter.sv - multi-cycle load/shift/rotate register, one bit per clock
// Optional rotate modes (ROL/ROR) are built only when LSS_ROTATE_EN is defined.
module lss_seq_shifter #(
   parameter int N  = 8,
   parameter int SW = 3
) (
   input  logic             clk,
   input  logic             rst,
   lss_seq_shifter_if.slave bus
);
   localparam logic [2:0]    M_SLL  = 3'b000;
   localparam logic [2:0]    M_SRL  = 3'b001;
   localparam logic [2:0]    M_SRA  = 3'b010;
`ifdef LSS_ROTATE_EN
   localparam logic [2:0]    M_ROL  = 3'b011;
   localparam logic [2:0]    M_ROR  = 3'b100;
`endif
   localparam logic [SW:0]   N_WIDE = (SW+1)'(N);
   localparam logic [SW-1:0] K_MAX  = SW'(N-1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [2:0]    op;
   logic [SW-1:0] cnt;
   logic [N-1:0]  data;
   logic          carry;

   logic          accept;
   logic          is_load;
   logic [SW-1:0] k;
   logic [N-1:0]  data_shift;
   logic          carry_shift;

   // Requests are only taken when no shift is in flight, including the DONE cycle.
   assign accept = bus.start && (state != S_SHIFT);

   always_comb begin
      is_load = 1'b1;
      case (bus.mode)
         M_SLL, M_SRL, M_SRA: is_load = 1'b0;
`ifdef LSS_ROTATE_EN
         M_ROL, M_ROR:        is_load = 1'b0;
`endif
         default:             is_load = 1'b1;
      endcase
   end

   always_comb begin
      k = bus.amt;
      if ({1'b0, bus.amt} >= N_WIDE) begin
         k = K_MAX;
      end
      if (is_load) begin
         k = '0;
      end
   end

   always_comb begin
      data_shift  = data;
      carry_shift = carry;
      case (op)
         M_SLL: begin
            data_shift  = {data[N-2:0], bus.sin};
            carry_shift = data[N-1];
         end
         M_SRL: begin
            data_shift  = {bus.sin, data[N-1:1]};
            carry_shift = data[0];
         end
         M_SRA: begin
            data_shift  = {data[N-1], data[N-1:1]};
            carry_shift = data[0];
         end
`ifdef LSS_ROTATE_EN
         M_ROL: begin
            data_shift  = {data[N-2:0], data[N-1]};
            carry_shift = data[N-1];
         end
         M_ROR: begin
            data_shift  = {data[0], data[N-1:1]};
            carry_shift = data[0];
         end
`endif
         default: begin
            data_shift  = data;
            carry_shift = carry;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (accept) begin
               state_nxt = (k == '0) ? S_DONE : S_SHIFT;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_SHIFT: begin
            if (cnt == SW'(1)) begin
               state_nxt = S_DONE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state == S_SHIFT);
      bus.done = (state == S_DONE);
      bus.dout = data;
      bus.cout = carry;
   end

   // Data path: load on accept, one step per SHIFT cycle, hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         data  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         op    <= M_SLL;
      end else if (accept) begin
         data  <= bus.din;
         carry <= 1'b0;
         cnt   <= k;
         op    <= bus.mode;
      end else if (state == S_SHIFT) begin
         data  <= data_shift;
         carry <= carry_shift;
         cnt   <= cnt - SW'(1);
      end
   end
endmodule

// File: tb/tb_lss_seq_shifter.sv
// tb/tb_lss_seq_shifter.sv - self-checking bench for lss_seq_shifter (N=8, SW=4)
// Closed-form result model plus directed literal checks and randomized traffic.
module tb_lss_seq_shifter;
   localparam int N  = 8;
   localparam int SW = 4;
`ifdef LSS_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lss_seq_shifter_if #(.N(N), .SW(SW)) bus ();
   lss_seq_shifter #(.N(N), .SW(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit is_load_ref(input logic [2:0] m);
      return (m > 3'd4) || (!ROT && (m == 3'd3 || m == 3'd4));
   endfunction

   // Final value of k single-bit operations, written as whole-word arithmetic.
   function automatic void ref_result(input logic [2:0] op, input logic [7:0] d, input int k,
                                      input bit s[$], output logic [7:0] r, output logic c);
      r = d;
      c = 1'b0;
      case (op)
         3'd0: begin
            r = d << k;
            for (int i = 0; i < k; i++) r[k-1-i] = s[i];
            c = d[N-k];
         end
         3'd1: begin
            r = d >> k;
            for (int i = 0; i < k; i++) r[N-k+i] = s[i];
            c = d[k-1];
         end
         3'd2: begin
            r = 8'($signed(d) >>> k);
            c = d[k-1];
         end
         3'd3: begin
            r = (d << k) | (d >> (N-k));
            c = r[0];
         end
         3'd4: begin
            r = (d >> k) | (d << (N-k));
            c = r[N-1];
         end
         default: begin
            r = d;
            c = 1'b0;
         end
      endcase
   endfunction

   int         e      = 0;
   int         acc    = 0;
   int         mk     = 0;
   bit         m_act  = 1'b0;
   bit         chk_en = 1'b0;
   logic [2:0] m_op;
   logic [7:0] m_din;
   logic [7:0] m_dout = 8'h00;
   logic       m_cout = 1'b0;
   bit         sq[$];
   bit         prev_busy;
   bit         eb;
   bit         ed;

   always @(posedge clk) begin
      e = e + 1;
      if (rst) begin
         m_act  = 1'b0;
         m_dout = 8'h00;
         m_cout = 1'b0;
         chk_en = 1'b1;
         sq.delete();
      end else begin
         prev_busy = m_act && (e - 1 >= acc) && (e - 1 < acc + mk);
         if (prev_busy) begin
            sq.push_back(bus.sin);
            if (e == acc + mk) ref_result(m_op, m_din, mk, sq, m_dout, m_cout);
         end else if (bus.start) begin
            m_act = 1'b1;
            acc   = e;
            m_op  = bus.mode;
            m_din = bus.din;
            mk    = is_load_ref(bus.mode) ? 0 : ((int'(bus.amt) >= N) ? N - 1 : int'(bus.amt));
            sq.delete();
            if (mk == 0) begin
               m_dout = bus.din;
               m_cout = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         eb = m_act && (e >= acc) && (e < acc + mk);
         ed = m_act && (e == acc + mk);
         chk("busy", bus.busy, eb);
         chk("done", bus.done, ed);
         if (!eb) begin
            chk("dout", bus.dout, m_dout);
            chk("cout", bus.cout, m_cout);
         end
      end
   end

   task automatic wait_done(output bit got, output int lat, output int nb);
      got = 1'b0;
      lat = 0;
      nb  = 0;
      for (int i = 0; i < 24 && !got; i++) begin
         if (bus.done) begin
            got = 1'b1;
            lat = i;
         end else begin
            if (bus.busy) nb++;
            @(negedge clk);
         end
      end
      chk("done_seen", got, 1'b1);
   endtask

   task automatic run_op(input logic [2:0] m, input logic [3:0] a, input logic [7:0] d,
                         input logic s, output int lat, output int nb,
                         output logic [7:0] rd, output logic rc);
      bit got;
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = m;
      bus.amt   = a;
      bus.din   = d;
      bus.sin   = s;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(got, lat, nb);
      rd = bus.dout;
      rc = bus.cout;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat;
      int         nb;
      int         seen;
      bit         got;
      logic [7:0] rd;
      logic       rc;

      bus.start = 1'b0;
      bus.mode  = 3'd0;
      bus.amt   = '0;
      bus.din   = 8'h00;
      bus.sin   = 1'b0;
      rst       = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_dout", bus.dout, 8'h00);
      chk("rst_cout", bus.cout, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);

      run_op(3'd0, 4'd3, 8'b1001_0110, 1'b0, lat, nb, rd, rc);
      chk("sll_dout", rd, 8'b1011_0000);
      chk("sll_cout", rc, 1'b0);
      chk("sll_lat", lat, 3);
      chk("sll_busy", nb, 3);
      chk("model_sll", m_dout, 8'hB0);

      run_op(3'd2, 4'd2, 8'b1000_0001, 1'b0, lat, nb, rd, rc);
      chk("sra_dout", rd, 8'b1110_0000);
      chk("sra_cout", rc, 1'b0);
      chk("sra_lat", lat, 2);

      run_op(3'd1, 4'd7, 8'h00, 1'b1, lat, nb, rd, rc);
      chk("srl_dout", rd, 8'hFE);
      chk("srl_cout", rc, 1'b0);
      chk("srl_lat", lat, 7);
      chk("model_srl", m_dout, 8'hFE);

      run_op(3'd4, 4'd1, 8'b0000_0011, 1'b0, lat, nb, rd, rc);
`ifdef LSS_ROTATE_EN
      chk("ror_dout", rd, 8'b1000_0001);
      chk("ror_cout", rc, 1'b1);
      chk("ror_lat", lat, 1);
`else
      chk("ror_dout", rd, 8'b0000_0011);
      chk("ror_cout", rc, 1'b0);
      chk("ror_lat", lat, 0);
      chk("ror_busy", nb, 0);
`endif

      run_op(3'd0, 4'd0, 8'hA5, 1'b0, lat, nb, rd, rc);
      chk("amt0_dout", rd, 8'hA5);
      chk("amt0_lat", lat, 0);
      chk("amt0_busy", nb, 0);

      run_op(3'd0, 4'd12, 8'hFF, 1'b0, lat, nb, rd, rc);
      chk("clamp_dout", rd, 8'h80);
      chk("clamp_cout", rc, 1'b1);
      chk("clamp_lat", lat, 7);

      run_op(3'd2, 4'd15, 8'h80, 1'b0, lat, nb, rd, rc);
      chk("clamp_sra_dout", rd, 8'hFF);
      chk("clamp_sra_lat", lat, 7);

      // A second request while busy must not disturb the running shift.
      @(negedge clk);
      bus.start = 1'b1;
      bus.mode  = 3'd0;
      bus.amt   = 4'd5;
      bus.din   = 8'h81;
      bus.sin   = 1'b0;
      @(negedge clk);
      bus.mode  = 3'd3;
      bus.amt   = 4'd1;
      bus.din   = 8'hFF;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(got, lat, nb);
      chk("ign_dout", bus.dout, 8'h20);
      chk("ign_cout", bus.cout, 1'b0);
      chk("ign_lat", lat + 1, 5);

      bus.start = 1'b1;
      bus.mode  = 3'd1;
      bus.amt   = 4'd1;
      bus.din   = 8'h80;
      @(negedge clk);
      chk("b2b_busy", bus.busy, 1'b1);
      bus.start = 1'b0;
      @(negedge clk);
      chk("b2b_done", bus.done, 1'b1);
      chk("b2b_dout", bus.dout, 8'h40);

      bus.start = 1'b1;
      bus.mode  = 3'd0;
      bus.amt   = 4'd5;
      bus.din   = 8'hFF;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_dout", bus.dout, 8'h00);
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_done", bus.done, 1'b0);
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen++;
      end
      chk("abort_quiet", seen, 0);

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 199) == 0);
         bus.sin   = 1'($urandom);
         bus.start = ($urandom_range(0, 3) == 0);
         bus.mode  = 3'($urandom_range(0, 7));
         bus.amt   = 4'($urandom);
         bus.din   = 8'($urandom);
      end
      @(negedge clk);
      rst       = 1'b0;
      bus.start = 1'b0;
      repeat (20) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/lss_seq_shifter.md
# lss_seq_shifter

Parametrised multi-cycle load/shift/rotate register. Generalises the load/store/shift register to N bits, five shift modes, a programmable shift count and a start/busy/done handshake. It performs one bit-shift per clock, so arithmetic and control datapaths can run variable-amount shifts without a barrel shifter. It sits beside the ALU and is sequenced by the control FSM through `start`/`done`.

## Interface
Parameters:
- `N`, 8, data width; N >= 2
- `SW`, 3, shift-amount width; must satisfy 2^SW >= N

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only when `busy`=0
- `mode`  in  3  operation, sampled with `start`
- `amt`  in  SW  shift count k, sampled with `start`; values >= N are clamped to N-1
- `din`  in  N  parallel load value, sampled with `start`
- `sin`  in  1  serial fill bit for SLL/SRL, sampled on every shift cycle
- `busy`  out  1  high while in SHIFT state
- `done`  out  1  one-cycle pulse: `dout`/`cout` final
- `dout`  out  N  register contents
- `cout`  out  1  last bit shifted or rotated out

## Operation
- Mode codes:
  - 000 SLL: shift left, LSB fills from `sin`.
  - 001 SRL: shift right, MSB fills from `sin`.
  - 010 SRA: shift right, MSB replicates itself.
  - 011 ROL: rotate left.
  - 100 ROR: rotate right.
  - 101–111 LOAD: load only; `amt` is treated as 0.
- States: IDLE, SHIFT, DONE.
- Accepting a request: IDLE or DONE with `start`=1.
  - `dout` <= `din`, `cout` <= 0, cnt <= k.
  - Next state is DONE if k=0, else SHIFT.
- SHIFT, each cycle:
  - One 1-bit operation on `dout`; `cout` <= the bit that left the register (the wrapped bit for rotates).
  - cnt <= cnt-1.
  - When cnt=1, next state is DONE.
- DONE:
  - `done`=1 for exactly one cycle.
  - Next state is IDLE, or an immediate new accept if `start`=1.
- `start` while `busy`=1 is ignored: no effect on `mode`/`amt`/`din` or on the state.
- `dout` and `cout` hold their values in IDLE and DONE until the next accepted `start`.
- Outputs:
  - `busy` = (state==SHIFT).
  - `done` = (state==DONE).
  - Both are decoded from registered state only; no combinational path from inputs.

## Timing
- Reset values: state IDLE, `dout`=0, `cout`=0, `done`=0, `busy`=0, cnt=0.
- Latency: `start` sampled at edge t, k>0 → `busy` high in cycles t..t+k-1 (k cycles), `done` high in cycle t+k (the cycle after edge t+k).
- k=0 or LOAD → `done` high in the cycle after edge t, `busy` never asserts.
- Back-to-back: `start` held during the `done` cycle is accepted at that edge; there are no idle cycles between operations.
- `rst` asserted mid-operation aborts at that edge. No `done` is issued and all outputs go to their reset values. `rst` dominates `start`.
- `sin` is sampled per shift cycle, so it may change during SHIFT.
- Clamp rule: `amt` >= N is treated as N-1. Example: N=8, SW=4, `amt`=12 → 7 shifts.

## Configuration
- `LSS_ROTATE_EN` defined: ROL/ROR are implemented as above.
- `LSS_ROTATE_EN` undefined: codes 011/100 decode as LOAD. `dout`=`din` and `done` asserts after 1 cycle; the rotate muxing is not synthesised.

## Test plan
- Reset, then idle: `dout`=00, `cout`=0, `busy`=0, `done`=0 held.
- SLL: `din`=8'b1001_0110, `amt`=3, `sin`=0.
  - `busy` high 3 cycles; `done` in cycle t+3.
  - `dout`=8'b1011_0000, `cout`=0.
- SRA: `din`=8'b1000_0001, `amt`=2 → `dout`=8'b1110_0000, `cout`=0, `done` at t+2.
- SRL with `sin`=1: `din`=8'h00, `amt`=7 → `dout`=8'hFE, `cout`=0.
- ROR: `din`=8'b0000_0011, `amt`=1.
  - With `LSS_ROTATE_EN`: `dout`=8'b1000_0001, `cout`=1, `done` at t+1.
  - Without `LSS_ROTATE_EN`: `dout`=8'b0000_0011, `done` at t+1, `busy` never high.
- Handshake edge cases:
  - `amt`=0 → `dout`=`din`, `done` at t+1.
  - `start` with a different `din` during `busy` is ignored; the result is unchanged.
  - `start` held in the `done` cycle launches the next operation immediately.
  - `rst` pulse at shift cycle 2 of a 5-shift operation → `dout`=0, no `done`, state IDLE.
